// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read port between fetch (master) and memory (slave)
//   mem_addr        fetch address, driven by the master
//   mem_rd          read request, driven by the master
//   mem_rddata      read data, valid when mem_rd=1 and mem_waitrequest=0
//   mem_waitrequest memory stall; the master holds its request while high
interface instr_fetch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rddata;
   logic              mem_waitrequest;
   modport master (output mem_addr, mem_rd, input mem_rddata, mem_waitrequest);
   modport slave  (input mem_addr, mem_rd, output mem_rddata, mem_waitrequest);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, instruction fetch/hold FSM and instruction-register field slicing
//   clk, reset        clock and synchronous active-high reset
//   bus               instruction-memory read port (instr_fetch_if.master)
//   o_fetch_owns_mem  high in FETCH; selects fetch as owner of the memory port
//   o_ir_valid        instruction register valid for decode/execute (HOLD)
//   o_instr           raw instruction register; o_opcode/o_rx/o_ry/o_imm8/o_imm11 are slices
//   o_pc, o_pc_plus2  current instruction address and its link value
//   i_pc_src          00 branch, 01 register-indirect, 10 sequential, 11 illegal
//   i_br_taken, i_br_offset, i_rind_addr  next-PC operands, sampled on i_exec_done
//   i_exec_done       one-cycle pulse ending execute
//   o_halted          fetch stopped on an illegal opcode
// Optional: define IFETCH_HALT_ON_ILLEGAL_EN to halt on pc_src=11; otherwise 11 is sequential.
module instr_fetch #(
   parameter int              ADDR_W   = 16,
   parameter int              DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   instr_fetch_if.master     bus,
   output logic              o_fetch_owns_mem,
   output logic              o_ir_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [4:0]        o_opcode,
   output logic [2:0]        o_rx,
   output logic [2:0]        o_ry,
   output logic [7:0]        o_imm8,
   output logic [10:0]       o_imm11,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_pc_plus2,
   input  logic [1:0]        i_pc_src,
   input  logic              i_br_taken,
   input  logic [ADDR_W-1:0] i_br_offset,
   input  logic [ADDR_W-1:0] i_rind_addr,
   input  logic              i_exec_done,
   output logic              o_halted
);
   typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_instr;
   logic              r_ir_valid;
   logic              w_fetch;
   logic [ADDR_W-1:0] w_pc_plus2;
   logic [ADDR_W-1:0] w_br_target;
   logic [ADDR_W-1:0] w_next_pc;
`ifdef IFETCH_HALT_ON_ILLEGAL_EN
   logic              r_halted;
   assign o_halted = r_halted;
`else
   assign o_halted = 1'b0;
`endif
   // Gated by reset so the request is withdrawn while reset is held, yet
   // appears in the very first cycle after release.
   assign w_fetch          = (r_state == FETCH) && !reset;
   assign bus.mem_rd       = w_fetch;
   assign bus.mem_addr     = r_pc;
   assign o_fetch_owns_mem = w_fetch;
   assign o_ir_valid       = r_ir_valid;
   assign o_instr          = r_instr;
   assign o_opcode         = r_instr[4:0];
   assign o_rx             = r_instr[7:5];
   assign o_ry             = r_instr[10:8];
   assign o_imm8           = r_instr[15:8];
   assign o_imm11          = r_instr[15:5];
   assign o_pc             = r_pc;
   assign o_pc_plus2       = w_pc_plus2;
   assign w_pc_plus2       = r_pc + ADDR_W'(2);
   // Offset counts 16-bit words, so it is doubled into a byte offset.
   assign w_br_target      = r_pc + {i_br_offset[ADDR_W-2:0], 1'b0};
   // pc_src=11 falls through to sequential; when halting is enabled the
   // value is never loaded because the FSM goes to HALT instead.
   assign w_next_pc        = (i_pc_src == 2'b01) ? {i_rind_addr[ADDR_W-1:1], 1'b0}
                           : (i_pc_src == 2'b00 && i_br_taken) ? w_br_target
                           : w_pc_plus2;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= FETCH;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_ir_valid <= 1'b0;
`ifdef IFETCH_HALT_ON_ILLEGAL_EN
         r_halted   <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH: begin
               if (!bus.mem_waitrequest) begin
                  r_instr    <= bus.mem_rddata;
                  r_ir_valid <= 1'b1;
                  r_state    <= HOLD;
               end
            end
            HOLD: begin
               if (i_exec_done) begin
                  r_ir_valid <= 1'b0;
`ifdef IFETCH_HALT_ON_ILLEGAL_EN
                  if (i_pc_src == 2'b11) begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_state <= FETCH;
                  end
`else
                  r_pc    <= w_next_pc;
                  r_state <= FETCH;
`endif
               end
            end
            HALT: r_ir_valid <= 1'b0;
            default: r_state <= FETCH;
         endcase
      end
   end
endmodule
